cv32e41p_prio_int_controller: RTL and testbench
===============================================

CV32E41P_PRIO_INT_CONTROLLER -- requirements
Module: cv32e41p_prio_int_controller

Interface
REQ-001 The block SHALL have parameter NUM_IRQ, default 32, legal range 2..64: number of interrupt lines.
REQ-002 The block SHALL have parameter PRIO_W, default 3, legal range 1..8: priority level width.
REQ-003 The block SHALL derive localparam ID_W = $clog2(NUM_IRQ): interrupt id width.
REQ-004 Port list (clock and reset first):
 - clk  in  1  core clock
 - rst_n  in  1  reset; synchronous, active-low
 - irq_i  in  NUM_IRQ  raw interrupt lines
 - irq_edge_i  in  NUM_IRQ  per-line mode; 1 = rising-edge, 0 = level
 - irq_prio_i  in  NUM_IRQ*PRIO_W  per-line priority, line n at bits [n*PRIO_W +: PRIO_W]
 - mie_i  in  NUM_IRQ  per-line enable
 - m_ie_i  in  1  global enable
 - threshold_i  in  PRIO_W  current priority level
 - irq_ack_i  in  1  controller accepts the presented interrupt
 - irq_req_ctrl_o  out  1  interrupt request
 - irq_id_ctrl_o  out  ID_W  winning id
 - irq_prio_ctrl_o  out  PRIO_W  winning priority
 - irq_wu_ctrl_o  out  1  wake-up
 - mip_o  out  NUM_IRQ  pending vector

Function
REQ-005 The block SHALL register irq_i into irq_q every cycle, and irq_q into irq_prev.
REQ-006 A level line's pending bit SHALL equal irq_q[n].
REQ-007 An edge line's pending register SHALL set on the cycle after irq_q[n]=1 with irq_prev[n]=0.
REQ-008 An edge line's pending register SHALL clear on irq_ack_i when irq_id_ctrl_o=n.
REQ-009 If an ack and a new edge hit the same edge line in the same cycle, the set SHALL win.
REQ-010 Candidates SHALL be pending & mie_i, with the acked id masked for the cycle of irq_ack_i.
REQ-011 Arbitration SHALL select the candidate with the highest irq_prio_i; ties SHALL go to the highest id.
REQ-012 irq_req_ctrl_o, irq_id_ctrl_o and irq_prio_ctrl_o SHALL be registered from the arbitration result every cycle.
REQ-013 The registered request SHALL be 1 only when m_ie_i=1, a candidate exists, and the winner's priority > threshold_i (unsigned).
REQ-014 If no request is made, irq_id_ctrl_o and irq_prio_ctrl_o SHALL hold their previous values.
REQ-015 Latency from irq_i rising to irq_req_ctrl_o SHALL be 2 cycles for level lines and 3 cycles for edge lines.
REQ-016 irq_ack_i SHALL be ignored when irq_req_ctrl_o=0.
REQ-017 The cycle after an ack SHALL not present the acked id unless it was re-set per REQ-009.
REQ-018 irq_wu_ctrl_o SHALL be combinational: |(irq_i & mie_i), independent of clock.
REQ-019 mip_o SHALL equal the pending vector.
REQ-020 Level mode changing to edge mode SHALL start with pending = 0 for that line.

Reset
REQ-021 With rst_n=0 at a clk edge, irq_q, irq_prev, edge-pending, irq_req_ctrl_o, irq_id_ctrl_o and irq_prio_ctrl_o SHALL all become 0.
REQ-022 A reset mid-request SHALL drop irq_req_ctrl_o on the next edge; pending edges SHALL be lost.

Structure
REQ-023 Defaults CSR_NUM_IRQ and CSR_PRIO_W SHALL live in cv32e41p_pkg, next to the CSR_M*IX_BIT constants.
REQ-024 Arbitration SHALL be a combinational sub-module cv32e41p_prio_arbiter (NUM_IRQ, PRIO_W), built as a log-depth compare tree.

Verification
REQ-025 Level line 11, prio 5, threshold 0, irq_i[11] rising at cycle 0 -> req=1, id=11, prio=5 at cycle 2.
REQ-026 Edge line 3, prio 2, 1-cycle pulse -> req at cycle 3; ack -> req=0 the next cycle; mip_o[3]=0.
REQ-027 Lines 7 and 20 both prio 4 pending -> id=20; line 7 raised to prio 6 -> id=7.
REQ-028 Threshold 4, only candidate prio 4 -> req=0; threshold 3 -> req=1.
REQ-029 Edge line 5: ack and a new rising edge in the same cycle -> mip_o[5] stays 1, id 5 re-presented.
REQ-030 m_ie_i=0 with irq_i[11]=1 and mie_i[11]=1 -> req=0, irq_wu_ctrl_o=1; rst_n=0 mid-request -> all outputs 0 next edge.

Source files
------------

// File: rtl/cv32e41p_pkg.sv
// Shared core constants: mip/mie bit positions and interrupt controller defaults.
package cv32e41p_pkg;

  localparam int CSR_MSIX_BIT = 3;
  localparam int CSR_MTIX_BIT = 7;
  localparam int CSR_MEIX_BIT = 11;

  localparam int CSR_NUM_IRQ = 32;
  localparam int CSR_PRIO_W  = 3;

endpackage

// File: rtl/cv32e41p_prio_arbiter.sv
// Combinational priority arbiter: pairwise reduction tree.
// Highest priority wins; on equal priority the higher id wins.
module cv32e41p_prio_arbiter
  import cv32e41p_pkg::*;
#(
  parameter  int NUM_IRQ = CSR_NUM_IRQ,
  parameter  int PRIO_W  = CSR_PRIO_W,
  localparam int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0]        cand,
  input  logic [NUM_IRQ*PRIO_W-1:0] prio,
  output logic                      win_valid,
  output logic [ID_W-1:0]           win_id,
  output logic [PRIO_W-1:0]         win_prio
);

  localparam int LEAVES = 1 << ID_W;

  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   id;
    logic [PRIO_W-1:0] prio;
  } node_t;

  logic [LEAVES-1:0]        cand_pad;
  logic [LEAVES*PRIO_W-1:0] prio_pad;

  // Pad to a power of two so every tree level pairs up cleanly.
  for (genvar gi = 0; gi < LEAVES; gi++) begin : gen_pad
    if (gi < NUM_IRQ) begin : gen_real
      assign cand_pad[gi]                    = cand[gi];
      assign prio_pad[gi*PRIO_W +: PRIO_W]   = prio[gi*PRIO_W +: PRIO_W];
    end else begin : gen_fill
      assign cand_pad[gi]                    = 1'b0;
      assign prio_pad[gi*PRIO_W +: PRIO_W]   = '0;
    end
  end

  function automatic node_t reduce_tree(input logic [LEAVES-1:0]        c,
                                        input logic [LEAVES*PRIO_W-1:0] p);
    node_t nodes [LEAVES];
    node_t lo;
    node_t hi;
    for (int i = 0; i < LEAVES; i++) begin
      nodes[i].valid = c[i];
      nodes[i].id    = ID_W'(i);
      nodes[i].prio  = p[i*PRIO_W +: PRIO_W];
    end
    // In-place halving: slot i is overwritten only after its parent level consumed it.
    for (int width = LEAVES / 2; width >= 1; width = width / 2) begin
      for (int i = 0; i < width; i++) begin
        lo = nodes[2*i];
        hi = nodes[2*i+1];
        nodes[i] = (hi.valid && (!lo.valid || hi.prio >= lo.prio)) ? hi : lo;
      end
    end
    return nodes[0];
  endfunction

  node_t winner;

  always_comb begin
    winner    = reduce_tree(cand_pad, prio_pad);
    win_valid = winner.valid;
    win_id    = winner.id;
    win_prio  = winner.prio;
  end

endmodule

// File: rtl/cv32e41p_prio_int_controller.sv
// Prioritised interrupt controller: level/edge pending tracking, masking,
// arbitration and a registered request/id/priority towards the core.
module cv32e41p_prio_int_controller
  import cv32e41p_pkg::*;
#(
  parameter  int NUM_IRQ = CSR_NUM_IRQ,
  parameter  int PRIO_W  = CSR_PRIO_W,
  localparam int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_IRQ-1:0]        irq_i,
  input  logic [NUM_IRQ-1:0]        irq_edge_i,
  input  logic [NUM_IRQ*PRIO_W-1:0] irq_prio_i,
  input  logic [NUM_IRQ-1:0]        mie_i,
  input  logic                      m_ie_i,
  input  logic [PRIO_W-1:0]         threshold_i,
  input  logic                      irq_ack_i,
  output logic                      irq_req_ctrl_o,
  output logic [ID_W-1:0]           irq_id_ctrl_o,
  output logic [PRIO_W-1:0]         irq_prio_ctrl_o,
  output logic                      irq_wu_ctrl_o,
  output logic [NUM_IRQ-1:0]        mip_o
);

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] irq_prev;
  logic [NUM_IRQ-1:0] edge_pend_reg;
  logic [NUM_IRQ-1:0] edge_pend_next;
  logic [NUM_IRQ-1:0] edge_set;
  logic [NUM_IRQ-1:0] ack_mask;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] cand;
  logic               ack_ok;
  logic               win_valid;
  logic [ID_W-1:0]    win_id;
  logic [PRIO_W-1:0]  win_prio;
  logic               req_next;

  // An ack only counts while a request is actually being presented.
  assign ack_ok   = irq_ack_i & irq_req_ctrl_o;
  assign ack_mask = ack_ok ? ({{(NUM_IRQ-1){1'b0}}, 1'b1} << irq_id_ctrl_o) : '0;
  assign edge_set = irq_q & ~irq_prev & irq_edge_i;

  // Set beats clear; level-mode lines keep this register at zero.
  assign edge_pend_next = irq_edge_i & (edge_set | (edge_pend_reg & ~ack_mask));

  assign pending = (irq_edge_i & edge_pend_reg) | (~irq_edge_i & irq_q);
  assign cand    = pending & mie_i & ~ack_mask;

  cv32e41p_prio_arbiter #(
    .NUM_IRQ (NUM_IRQ),
    .PRIO_W  (PRIO_W)
  ) u_arbiter (
    .cand      (cand),
    .prio      (irq_prio_i),
    .win_valid (win_valid),
    .win_id    (win_id),
    .win_prio  (win_prio)
  );

  assign req_next = m_ie_i & win_valid & (win_prio > threshold_i);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_q           <= '0;
      irq_prev        <= '0;
      edge_pend_reg   <= '0;
      irq_req_ctrl_o  <= 1'b0;
      irq_id_ctrl_o   <= '0;
      irq_prio_ctrl_o <= '0;
    end else begin
      irq_q          <= irq_i;
      irq_prev       <= irq_q;
      edge_pend_reg  <= edge_pend_next;
      irq_req_ctrl_o <= req_next;
      if (req_next) begin
        irq_id_ctrl_o   <= win_id;
        irq_prio_ctrl_o <= win_prio;
      end
    end
  end

  assign irq_wu_ctrl_o = |(irq_i & mie_i);
  assign mip_o         = pending;

endmodule

// File: tb/tb_cv32e41p_prio_int_controller.sv
// Bench for the prioritised interrupt controller: directed scenarios plus
// randomized traffic against a cycle-level behavioural model.
module tb_cv32e41p_prio_int_controller;

  localparam int N  = 32;
  localparam int PW = 3;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  irq;
  logic [N-1:0]  irq_edge;
  logic [N*PW-1:0] irq_prio;
  logic [N-1:0]  mie;
  logic          m_ie;
  logic [PW-1:0] thr;
  logic          ack;
  logic          req;
  logic [IW-1:0] id;
  logic [PW-1:0] prio;
  logic          wu;
  logic [N-1:0]  mip;

  int checks = 0;
  int errors = 0;

  // Model state
  bit [N-1:0]  m_q;
  bit [N-1:0]  m_prev;
  bit [N-1:0]  m_pend;
  bit          m_req;
  bit [IW-1:0] m_id;
  bit [PW-1:0] m_prio;

  always #5 clk = ~clk;

  cv32e41p_prio_int_controller dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .irq_i           (irq),
    .irq_edge_i      (irq_edge),
    .irq_prio_i      (irq_prio),
    .mie_i           (mie),
    .m_ie_i          (m_ie),
    .threshold_i     (thr),
    .irq_ack_i       (ack),
    .irq_req_ctrl_o  (req),
    .irq_id_ctrl_o   (id),
    .irq_prio_ctrl_o (prio),
    .irq_wu_ctrl_o   (wu),
    .mip_o           (mip)
  );

  // Advance one clock; the model applies the spec rules to the inputs seen at the edge.
  task automatic tick();
    bit [N-1:0]  npend;
    bit          nreq;
    bit [IW-1:0] nid;
    bit [PW-1:0] nprio;
    bit          ack_ok;
    bit          found;
    int          best;
    int          bp;
    ack_ok = ack && m_req;
    found = 0; best = 0; bp = 0;
    for (int n = 0; n < N; n++) begin
      bit p;
      bit c;
      bit acked;
      acked = ack_ok && (int'(m_id) == n);
      p = irq_edge[n] ? m_pend[n] : m_q[n];
      c = p && mie[n] && !acked;
      if (c && (!found || int'(irq_prio[n*PW +: PW]) >= bp)) begin
        found = 1; best = n; bp = int'(irq_prio[n*PW +: PW]);
      end
      npend[n] = irq_edge[n] && ((m_q[n] && !m_prev[n]) || (m_pend[n] && !acked));
    end
    nreq  = m_ie && found && (bp > int'(thr));
    nid   = nreq ? IW'(best) : m_id;
    nprio = nreq ? PW'(bp) : m_prio;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_q = '0; m_prev = '0; m_pend = '0; m_req = 0; m_id = '0; m_prio = '0;
    end else begin
      m_prev = m_q; m_q = irq; m_pend = npend; m_req = nreq; m_id = nid; m_prio = nprio;
    end
  endtask

  task automatic clear_inputs();
    irq = '0; irq_edge = '0; irq_prio = '0; mie = '0; m_ie = 1'b0; thr = '0; ack = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic set_prio(input int n, input int p);
    irq_prio[n*PW +: PW] = PW'(p);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    irq = '1; irq_edge = '0; irq_prio = '1; mie = '1; m_ie = 1'b1; thr = '0; ack = 1'b1;
    tick(); tick();
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", req); end
    checks++; if (id !== 5'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", id); end
    checks++; if (prio !== 3'd0) begin errors++; $display("FAIL reset_prio: got %0d want 0", prio); end
    checks++; if (mip !== 32'h0) begin errors++; $display("FAIL reset_mip: got %h want 0", mip); end
    $display("test_reset: req=%0b id=%0d prio=%0d mip=%h", req, id, prio, mip);
    do_reset();
  endtask

  task automatic test_level_latency();
    do_reset();
    set_prio(11, 5); mie[11] = 1'b1; m_ie = 1'b1; thr = '0;
    irq[11] = 1'b1;
    tick();
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL level_cyc1_req: got %0b want 0", req); end
    tick();
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL level_cyc2_req: got %0b want 1", req); end
    checks++; if (id !== 5'd11) begin errors++; $display("FAIL level_id: got %0d want 11", id); end
    checks++; if (prio !== 3'd5) begin errors++; $display("FAIL level_prio: got %0d want 5", prio); end
    $display("test_level_latency: req=%0b id=%0d prio=%0d", req, id, prio);
  endtask

  task automatic test_edge_ack();
    do_reset();
    irq_edge[3] = 1'b1; set_prio(3, 2); mie[3] = 1'b1; m_ie = 1'b1;
    irq[3] = 1'b1; tick();
    irq[3] = 1'b0; tick();
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL edge_cyc2_req: got %0b want 0", req); end
    checks++; if (mip[3] !== 1'b1) begin errors++; $display("FAIL edge_cyc2_mip3: got %0b want 1", mip[3]); end
    tick();
    checks++; if (req !== 1'b1 || id !== 5'd3 || prio !== 3'd2) begin
      errors++; $display("FAIL edge_cyc3: got req=%0b id=%0d prio=%0d want 1/3/2", req, id, prio);
    end
    ack = 1'b1; tick(); ack = 1'b0;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL edge_ack_req: got %0b want 0", req); end
    checks++; if (mip[3] !== 1'b0) begin errors++; $display("FAIL edge_ack_mip3: got %0b want 0", mip[3]); end
    tick();
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL edge_after_ack_req: got %0b want 0", req); end
    $display("test_edge_ack: req=%0b mip3=%0b", req, mip[3]);
  endtask

  task automatic test_tie_prio();
    do_reset();
    set_prio(7, 4); set_prio(20, 4); mie[7] = 1'b1; mie[20] = 1'b1; m_ie = 1'b1;
    irq[7] = 1'b1; irq[20] = 1'b1;
    tick(); tick();
    checks++; if (req !== 1'b1 || id !== 5'd20 || prio !== 3'd4) begin
      errors++; $display("FAIL tie_high_id: got req=%0b id=%0d prio=%0d want 1/20/4", req, id, prio);
    end
    set_prio(7, 6); tick();
    checks++; if (req !== 1'b1 || id !== 5'd7 || prio !== 3'd6) begin
      errors++; $display("FAIL raised_prio: got req=%0b id=%0d prio=%0d want 1/7/6", req, id, prio);
    end
    $display("test_tie_prio: id=%0d prio=%0d", id, prio);
  endtask

  task automatic test_threshold();
    do_reset();
    set_prio(9, 4); mie[9] = 1'b1; m_ie = 1'b1; thr = 3'd4; irq[9] = 1'b1;
    tick(); tick();
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL thr_equal_req: got %0b want 0", req); end
    thr = 3'd3; tick();
    checks++; if (req !== 1'b1 || id !== 5'd9) begin
      errors++; $display("FAIL thr_below: got req=%0b id=%0d want 1/9", req, id);
    end
    $display("test_threshold: req=%0b id=%0d", req, id);
  endtask

  task automatic test_ack_reedge();
    do_reset();
    irq_edge[5] = 1'b1; set_prio(5, 3); mie[5] = 1'b1; m_ie = 1'b1;
    irq[5] = 1'b1; tick();
    irq[5] = 1'b0; tick();
    irq[5] = 1'b1; tick();
    checks++; if (req !== 1'b1 || id !== 5'd5) begin
      errors++; $display("FAIL reedge_pre: got req=%0b id=%0d want 1/5", req, id);
    end
    ack = 1'b1; tick(); ack = 1'b0;
    checks++; if (mip[5] !== 1'b1) begin errors++; $display("FAIL reedge_mip5: got %0b want 1", mip[5]); end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL reedge_masked_req: got %0b want 0", req); end
    tick();
    checks++; if (req !== 1'b1 || id !== 5'd5) begin
      errors++; $display("FAIL reedge_represent: got req=%0b id=%0d want 1/5", req, id);
    end
    $display("test_ack_reedge: req=%0b id=%0d mip5=%0b", req, id, mip[5]);
  endtask

  task automatic test_global_and_reset();
    do_reset();
    set_prio(11, 5); mie[11] = 1'b1; m_ie = 1'b0; irq[11] = 1'b1;
    #1;
    checks++; if (wu !== 1'b1) begin errors++; $display("FAIL wu_comb: got %0b want 1", wu); end
    tick(); tick();
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL gie_off_req: got %0b want 0", req); end
    irq_edge[2] = 1'b1; mie[2] = 1'b1; set_prio(2, 7); irq[2] = 1'b1;
    m_ie = 1'b1; tick(); tick();
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL gie_on_req: got %0b want 1", req); end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    checks++; if (req !== 1'b0 || id !== 5'd0 || prio !== 3'd0 || mip !== 32'h0) begin
      errors++; $display("FAIL mid_reset: got req=%0b id=%0d prio=%0d mip=%h want all 0", req, id, prio, mip);
    end
    irq = '0; tick(); tick(); tick();
    checks++; if (mip[2] !== 1'b0) begin errors++; $display("FAIL edge_lost: got %0b want 0", mip[2]); end
    $display("test_global_and_reset: req=%0b mip=%h", req, mip);
  endtask

  task automatic test_random();
    bit [N-1:0] exp_mip;
    bit         exp_wu;
    do_reset();
    irq_edge = $urandom;
    for (int cyc = 0; cyc < 400; cyc++) begin
      irq = $urandom & $urandom;
      if ($urandom_range(15) == 0) irq_edge = $urandom;
      for (int n = 0; n < N; n++) if ($urandom_range(7) == 0) set_prio(n, int'($urandom_range(7)));
      mie   = $urandom | $urandom;
      m_ie  = ($urandom_range(7) != 0);
      thr   = PW'($urandom_range(4));
      ack   = ($urandom_range(2) != 0);
      rst_n = ($urandom_range(63) != 0);
      tick();
      for (int n = 0; n < N; n++) exp_mip[n] = irq_edge[n] ? m_pend[n] : m_q[n];
      exp_wu = |(irq & mie);
      checks++; if (req !== m_req) begin errors++; $display("FAIL rnd_req cyc %0d: got %0b want %0b", cyc, req, m_req); end
      checks++; if (id !== m_id) begin errors++; $display("FAIL rnd_id cyc %0d: got %0d want %0d", cyc, id, m_id); end
      checks++; if (prio !== m_prio) begin errors++; $display("FAIL rnd_prio cyc %0d: got %0d want %0d", cyc, prio, m_prio); end
      checks++; if (mip !== exp_mip) begin errors++; $display("FAIL rnd_mip cyc %0d: got %h want %h", cyc, mip, exp_mip); end
      checks++; if (wu !== exp_wu) begin errors++; $display("FAIL rnd_wu cyc %0d: got %0b want %0b", cyc, wu, exp_wu); end
      $display("rnd cyc %0d: req=%0b id=%0d prio=%0d mip=%h", cyc, req, id, prio, mip);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    m_q = '0; m_prev = '0; m_pend = '0; m_req = 0; m_id = '0; m_prio = '0;
    test_reset();
    test_level_latency();
    test_edge_ack();
    test_tie_prio();
    test_threshold();
    test_ack_reedge();
    test_global_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
